wptr_full_ctrl: RTL

Write-side pointer and flag controller for the asynchronous FIFO, running entirely in the write clock domain. It extends the basic full logic with three additions: a registered write-side occupancy count, a programmable almost-full flag, and a sticky overflow error flag. It takes the read pointer after it has passed through the two-flop synchroniser and drives the memory write address, the memory write enable, and the Gray write pointer that goes to the read-side synchroniser.

---
 rtl/wptr_full_ctrl_if.sv | 27 ++
 rtl/wptr_full_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO pointer bus: write request, synchronised read pointer and
// threshold in; write enable/address, Gray pointer and status flags out.
interface wptr_full_ctrl_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 winc;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic [ADDR_SIZE:0]   afull_thresh;
  logic                 wclr_ovf;
  logic                 wen;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 wovf;

  modport master (
    output winc, wq2_rptr, afull_thresh, wclr_ovf,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_rptr, afull_thresh, wclr_ovf,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, full and
// almost-full flags, write-side occupancy and a sticky overflow flag.
module wptr_full_ctrl #(
  parameter int ADDR_SIZE = 4
) (
  input logic             wclk,
  input logic             wrst,
  wptr_full_ctrl_if.slave bus
);
  localparam int PW = ADDR_SIZE + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] wptr_q;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wlevel_q;
  logic          wovf_q;

  logic          wen_c;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rbin;
  logic [PW-1:0] levelnext;
  logic          wfull_val;
  logic          walmost_full_val;
  logic          wovf_next;

  always_comb begin
    wen_c     = bus.winc & ~wfull_q;
    wbinnext  = wbin + PW'(wen_c);
    wgraynext = bin2gray(wbinnext);
    rbin      = gray2bin(bus.wq2_rptr);
    // Modular difference stays correct when wbin wraps past the read pointer.
    levelnext = wbinnext - rbin;
    // Full when the next write pointer is exactly one lap ahead of the read pointer.
    wfull_val = (wgraynext == {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                               bus.wq2_rptr[ADDR_SIZE-2:0]});
    walmost_full_val = (levelnext >= bus.afull_thresh);
    // A write attempt while full takes priority over a clear in the same cycle.
    wovf_next = wovf_q;
    if (bus.winc && wfull_q) begin
      wovf_next = 1'b1;
    end else if (bus.wclr_ovf) begin
      wovf_next = 1'b0;
    end
  end

  // Stage boundary: all pointer and flag state registered on wclk
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      wovf_q         <= 1'b0;
    end else begin
      wbin           <= wbinnext;
      wptr_q         <= wgraynext;
      wfull_q        <= wfull_val;
      walmost_full_q <= walmost_full_val;
      wlevel_q       <= levelnext;
      wovf_q         <= wovf_next;
    end
  end

  assign bus.wen          = wen_c;
  assign bus.waddr        = wbin[ADDR_SIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wovf         = wovf_q;
endmodule
